// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential radix-2 restoring divider.
// Provides the default operand width, the iteration counter width and the
// divider FSM state encoding. Imported by the interface, the iteration step
// and the top-level divider.
package seq_divider_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned CNT_W_DEFAULT = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage : seq_divider_pkg

// File: rtl/seq_divider_if.sv
// Request/response bundle between the execute stage and the divide engine.
// Signals:
//   dividend   - unsigned dividend magnitude
//   divitor    - unsigned divisor magnitude
//   req_in     - level request, held by the execute stage until ready_out
//   is_q_in    - 0 = return quotient, 1 = return remainder
//   ready_out  - one-cycle pulse, result_out valid
//   result_out - quotient or remainder
// master = execute stage, slave = divider.
interface seq_divider_if
    import seq_divider_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
);
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divitor;
    logic            req_in;
    logic            is_q_in;
    logic            ready_out;
    logic [XLEN-1:0] result_out;

    modport master (
        output dividend, divitor, req_in, is_q_in,
        input  ready_out, result_out
    );

    modport slave (
        input  dividend, divitor, req_in, is_q_in,
        output ready_out, result_out
    );
endinterface : seq_divider_if

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division iteration.
// Ports:
//   rem_c     - current partial remainder (always < divisor, fits XLEN bits)
//   quo_msb_c - next dividend bit shifted into the remainder
//   dsr_c     - divisor
//   rem_nxt_c - partial remainder after the trial subtract
//   q_bit_c   - quotient bit produced by this iteration
module seq_divider_div_step
    import seq_divider_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] rem_c,
    input  logic            quo_msb_c,
    input  logic [XLEN-1:0] dsr_c,
    output logic [XLEN-1:0] rem_nxt_c,
    output logic            q_bit_c
);
    logic [XLEN:0] trial_c;

    // Shift-in needs one extra bit so the compare sees the full trial value.
    assign trial_c = {rem_c, quo_msb_c};
    assign q_bit_c = (trial_c >= {1'b0, dsr_c});

    // After a successful subtract the result is below the divisor, so the
    // top bit of the difference is always zero and can be dropped.
    assign rem_nxt_c = q_bit_c ? XLEN'(trial_c - {1'b0, dsr_c})
                               : trial_c[XLEN-1:0];
endmodule : seq_divider_div_step

// File: rtl/seq_divider.sv
// Multi-cycle unsigned radix-2 restoring divider for the M-extension.
// Operands are latched in IDLE on req_in; XLEN iterations run in BUSY, one
// per cycle; DONE pulses ready_out with the quotient or remainder.
// Dropping req_in during BUSY aborts without a ready pulse.
// Ports:
//   clk_in   - core clock
//   reset_in - synchronous active-low reset
//   bus      - seq_divider_if slave (operands, request, result)
// Optional build macro SEQ_DIVIDER_EARLY_OUT_EN: divide-by-zero and
// dividend < divisor complete in one cycle, skipping BUSY.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic          clk_in,
    input  logic          reset_in,
    seq_divider_if.slave  bus
);
    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  rem;
    logic [XLEN-1:0]  quo;
    logic [XLEN-1:0]  dsr;
    logic             sel;
    logic             ready_q;
    logic [XLEN-1:0]  result_q;

    logic [XLEN-1:0]  rem_nxt_c;
    logic             q_bit_c;
    logic [XLEN-1:0]  quo_nxt_c;
    logic             last_iter_c;
    logic             early_out_c;
    logic [XLEN-1:0]  early_res_c;

    seq_divider_div_step #(.XLEN(XLEN)) u_step (
        .rem_c     (rem),
        .quo_msb_c (quo[XLEN-1]),
        .dsr_c     (dsr),
        .rem_nxt_c (rem_nxt_c),
        .q_bit_c   (q_bit_c)
    );

    assign quo_nxt_c   = {quo[XLEN-2:0], q_bit_c};
    assign last_iter_c = (cnt == CNT_W'(XLEN - 1));

    // Trivial cases whose answer is known without iterating.
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
    assign early_out_c = (bus.divitor == '0) || (bus.dividend < bus.divitor);
`else
    assign early_out_c = 1'b0;
`endif
    assign early_res_c = bus.is_q_in ? bus.dividend
                       : ((bus.divitor == '0) ? '1 : '0);

    // Divider FSM and datapath registers.
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dsr      <= '0;
            sel      <= 1'b0;
            ready_q  <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ready_q <= 1'b0;
                    if (bus.req_in) begin
                        if (early_out_c) begin
                            state    <= ST_DONE;
                            ready_q  <= 1'b1;
                            result_q <= early_res_c;
                        end else begin
                            state <= ST_BUSY;
                            quo   <= bus.dividend;
                            dsr   <= bus.divitor;
                            sel   <= bus.is_q_in;
                            rem   <= '0;
                            cnt   <= '0;
                        end
                    end
                end
                ST_BUSY: begin
                    // Abort has priority over the iteration, even the last one.
                    if (!bus.req_in) begin
                        state <= ST_IDLE;
                    end else begin
                        rem <= rem_nxt_c;
                        quo <= quo_nxt_c;
                        cnt <= cnt + CNT_W'(1);
                        if (last_iter_c) begin
                            state    <= ST_DONE;
                            ready_q  <= 1'b1;
                            result_q <= sel ? rem_nxt_c : quo_nxt_c;
                        end
                    end
                end
                ST_DONE: begin
                    ready_q <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ready_out  = ready_q;
    assign bus.result_out = result_q;
endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vectors with hand-computed
// results, a scoreboard queue of expected result/arrival cycle, and a monitor
// that pops and compares on every ready_out pulse.
module tb_seq_divider;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned FULL_LAT = XLEN + 1;

    typedef struct {
        logic [XLEN-1:0] res;
        int unsigned     cyc;
        string           name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned pcyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    exp_t sb[$];

    seq_divider_if #(.XLEN(XLEN)) bus ();

    seq_divider #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk_in   (clk),
        .reset_in (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pcyc <= pcyc + 1;

    function automatic int unsigned lat_for(input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
        if (b == '0 || a < b) return 1;
`endif
        return FULL_LAT;
    endfunction

    // Monitor: every ready pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.ready_out) begin
            exp_t e;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ready: got pulse at cycle %0d result %h, want no pulse",
                         pcyc, bus.result_out);
            end else begin
                e = sb.pop_front();
                n_cmp++;
                if (bus.result_out !== e.res) begin
                    n_bad++;
                    $display("FAIL %s result: got %h want %h", e.name, bus.result_out, e.res);
                end
                n_cmp++;
                if (pcyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL %s latency: got cycle %0d want %0d", e.name, pcyc, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [XLEN-1:0] got,
                         input logic [XLEN-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Wait (bounded) until the monitor has consumed every expectation.
    task automatic drain(input string name);
        int unsigned k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: got %0d pending results want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic present(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic q);
        bus.dividend = a;
        bus.divitor  = b;
        bus.is_q_in  = q;
        bus.req_in   = 1'b1;
    endtask

    task automatic do_div(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic q, input logic [XLEN-1:0] want,
                          input string name);
        exp_t e;
        @(negedge clk);
        present(a, b, q);
        e.res  = want;
        e.cyc  = pcyc + lat_for(a, b);
        e.name = name;
        sb.push_back(e);
        drain(name);
        bus.req_in = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        int unsigned p;
        bus.dividend = '0;
        bus.divitor  = '0;
        bus.is_q_in  = 1'b0;
        bus.req_in   = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_ready", {31'd0, bus.ready_out}, 32'd0);
        check("reset_result", bus.result_out, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_div(32'd100, 32'd7, 1'b0, 32'd14, "100/7_q");
        do_div(32'd100, 32'd7, 1'b1, 32'd2,  "100/7_r");
        do_div(32'h0000_1234, 32'd0, 1'b0, 32'hFFFF_FFFF, "div0_q");
        do_div(32'h0000_1234, 32'd0, 1'b1, 32'h0000_1234, "div0_r");
        do_div(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, "max/1_q");
        do_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'd0, "max/max_r");
        do_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1, "max/max_q");
        do_div(32'h8000_0000, 32'd3, 1'b0, 32'h2AAA_AAAA, "msb/3_q");
        do_div(32'h8000_0000, 32'd3, 1'b1, 32'd2, "msb/3_r");
        do_div(32'd5, 32'd9, 1'b0, 32'd0, "5/9_q");
        do_div(32'd5, 32'd9, 1'b1, 32'd5, "5/9_r");

        // Back-to-back with req held; operands disturbed mid-BUSY.
        @(negedge clk);
        present(32'd9, 32'd2, 1'b0);
        p = pcyc;
        e.res = 32'd4; e.cyc = p + FULL_LAT;      e.name = "b2b_first";  sb.push_back(e);
        e.res = 32'd1; e.cyc = p + 2*XLEN + 3;    e.name = "b2b_second"; sb.push_back(e);
        repeat (5) @(negedge clk);
        present(32'd100, 32'd3, 1'b1);
        repeat (15) @(negedge clk);
        present(32'd9, 32'd2, 1'b1);
        drain("b2b");
        bus.req_in = 1'b0;
        @(negedge clk);

        // Abort mid-BUSY: no pulse, result holds, then a normal divide.
        @(negedge clk);
        present(32'd1000, 32'd3, 1'b0);
        repeat (10) @(negedge clk);
        bus.req_in = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_result_hold", bus.result_out, 32'd1);
        do_div(32'd50, 32'd5, 1'b0, 32'd10, "after_abort_50/5");

        // Reset mid-BUSY.
        @(negedge clk);
        present(32'd77, 32'd5, 1'b0);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        bus.req_in = 1'b0;
        @(negedge clk);
        check("midreset_ready", {31'd0, bus.ready_out}, 32'd0);
        check("midreset_result", bus.result_out, 32'd0);
        rst_n = 1'b1;
        do_div(32'd100, 32'd7, 1'b0, 32'd14, "after_reset_100/7");

        repeat (40) @(negedge clk);
        drain("final");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule : tb_seq_divider
